// File: rtl/hsn_iter_sorter.sv
// hsn_iter_sorter: iterative odd-even transposition sorter.
// One rank of N_INPUTS/2 compare-and-swap cells is reused over N_INPUTS
// passes, with valid/ready handshakes on input and output.
// Optional feature macro: HSN_ITER_INDEX_EN adds original-lane index tags
// that travel with their words, exposed on index_out.
module hsn_iter_sorter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_INPUTS   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] data_in,
    input  logic                           direction,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_INPUTS*DATA_WIDTH-1:0] data_out,
`ifdef HSN_ITER_INDEX_EN
    output logic [N_INPUTS*$clog2(N_INPUTS)-1:0] index_out,
`endif
    output logic                           busy
);

    localparam int unsigned CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int unsigned IDX_W = CNT_W;
    localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(N_INPUTS - 1);

    // Reject odd or too-small lane counts at elaboration.
    generate
        if ((N_INPUTS < 2) || ((N_INPUTS % 2) != 0)) begin : g_bad_n
            $error("hsn_iter_sorter: N_INPUTS must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SORT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                                 state_q, state_d;
    logic [N_INPUTS-1:0][DATA_WIDTH-1:0]    data_q, data_d;
    logic [N_INPUTS-1:0][DATA_WIDTH-1:0]    pass_data_c;
    logic                                   dir_q, dir_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic                                   in_ready_q, in_ready_d;
    logic                                   out_valid_q, out_valid_d;
    logic                                   busy_q, busy_d;
    logic [N_INPUTS-2:0]                    swap_c;
`ifdef HSN_ITER_INDEX_EN
    logic [N_INPUTS-1:0][IDX_W-1:0]         idx_q, idx_d;
    logic [N_INPUTS-1:0][IDX_W-1:0]         pass_idx_c;
`endif

    // Swap decisions for the current pass: only pairs whose lower lane
    // parity matches the pass parity are active; equal words never swap.
    always_comb begin
        swap_c = '0;
        for (int unsigned i = 0; i + 1 < N_INPUTS; i++) begin
            if (1'(i) == cnt_q[0]) begin
                swap_c[i] = dir_q ? (data_q[i] < data_q[i+1])
                                  : (data_q[i] > data_q[i+1]);
            end
        end
    end

    // Apply the swaps; active pairs never overlap within one pass.
    always_comb begin
        pass_data_c = data_q;
`ifdef HSN_ITER_INDEX_EN
        pass_idx_c  = idx_q;
`endif
        for (int unsigned i = 0; i + 1 < N_INPUTS; i++) begin
            if (swap_c[i]) begin
                pass_data_c[i]   = data_q[i+1];
                pass_data_c[i+1] = data_q[i];
`ifdef HSN_ITER_INDEX_EN
                pass_idx_c[i]    = idx_q[i+1];
                pass_idx_c[i+1]  = idx_q[i];
`endif
            end
        end
    end

    // Next state, working register updates and registered status decode.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
`ifdef HSN_ITER_INDEX_EN
        idx_d   = idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = data_in;
                    dir_d   = direction;
                    cnt_d   = '0;
`ifdef HSN_ITER_INDEX_EN
                    for (int unsigned k = 0; k < N_INPUTS; k++) begin
                        idx_d[k] = IDX_W'(k);
                    end
`endif
                    state_d = S_SORT;
                end
            end
            S_SORT: begin
                data_d = pass_data_c;
`ifdef HSN_ITER_INDEX_EN
                idx_d  = pass_idx_c;
`endif
                if (cnt_q == LAST_PASS) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef HSN_ITER_INDEX_EN
            idx_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef HSN_ITER_INDEX_EN
            idx_q       <= idx_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign data_out  = data_q;
`ifdef HSN_ITER_INDEX_EN
    assign index_out = idx_q;
`endif

endmodule

// File: tb/tb_hsn_iter_sorter.sv
// Self-checking bench for hsn_iter_sorter: an 8x32 instance driven with
// directed and random vectors against a stable-sort reference, plus a
// 2-lane instance for the smallest legal configuration.
module tb_hsn_iter_sorter;

    localparam int unsigned DW = 32;
    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;

    typedef logic [DW-1:0] vec8_t [N];
    typedef int            idx8_t [N];

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [N*DW-1:0] data_in = '0;
    logic          direction = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N*DW-1:0] data_out;
    logic          busy;
`ifdef HSN_ITER_INDEX_EN
    logic [N*IW-1:0] index_out;
`endif

    logic          in_valid2  = 1'b0;
    logic          in_ready2;
    logic [2*DW-1:0] data_in2 = '0;
    logic          direction2 = 1'b0;
    logic          out_valid2;
    logic          out_ready2 = 1'b1;
    logic [2*DW-1:0] data_out2;
    logic          busy2;
`ifdef HSN_ITER_INDEX_EN
    logic [1:0]    index_out2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    hsn_iter_sorter #(.DATA_WIDTH(DW), .N_INPUTS(N)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .direction (direction),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
`ifdef HSN_ITER_INDEX_EN
        .index_out (index_out),
`endif
        .busy      (busy)
    );

    hsn_iter_sorter #(.DATA_WIDTH(DW), .N_INPUTS(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .data_in   (data_in2),
        .direction (direction2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .data_out  (data_out2),
`ifdef HSN_ITER_INDEX_EN
        .index_out (index_out2),
`endif
        .busy      (busy2)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges despite the bounded waits.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stable sort: each output slot takes the earliest remaining lane holding
    // the extreme remaining value, so equal words keep their input order.
    function automatic void ref_sort(input vec8_t v, input bit dir,
                                     output vec8_t o, output idx8_t idx);
        bit used [N];
        for (int k = 0; k < N; k++) used[k] = 1'b0;
        for (int p = 0; p < N; p++) begin
            int best;
            best = -1;
            for (int j = 0; j < N; j++) begin
                if (!used[j]) begin
                    if (best < 0) best = j;
                    else if (dir ? (v[j] > v[best]) : (v[j] < v[best])) best = j;
                end
            end
            used[best] = 1'b1;
            o[p]   = v[best];
            idx[p] = best;
        end
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        case ($urandom_range(0, 3))
            0:       w = DW'($urandom_range(0, 7));
            1:       w = $urandom;
            2: begin
                case ($urandom_range(0, 2))
                    0:       w = 32'h0000_0000;
                    1:       w = 32'h8000_0000;
                    default: w = 32'hFFFF_FFFF;
                endcase
            end
            default: w = DW'($urandom_range(0, 3));
        endcase
        return w;
    endfunction

    task automatic check_out8(input string name, input vec8_t e, input idx8_t ei);
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("%s lane%0d", name, k), 64'(data_out[k*DW +: DW]), 64'(e[k]));
`ifdef HSN_ITER_INDEX_EN
            check_eq($sformatf("%s idx%0d", name, k), 64'(index_out[k*IW +: IW]), 64'(ei[k]));
`endif
        end
    endtask

    task automatic send8(input string name, input vec8_t v, input bit dir);
        for (int k = 0; k < N; k++) data_in[k*DW +: DW] = v[k];
        direction = dir;
        in_valid  = 1'b1;
        check_eq({name, " in_ready idle"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        data_in  = {8{$urandom}};
        check_eq({name, " busy sort"}, 64'(busy), 64'd1);
        check_eq({name, " in_ready sort"}, 64'(in_ready), 64'd0);
    endtask

    task automatic recv8(input string name, input vec8_t v, input bit dir, input int hold,
                         input bit scramble, input bit pend, input vec8_t pv, input bit pdir);
        vec8_t e;
        idx8_t ei;
        int    lat;
        ref_sort(v, dir, e, ei);
        out_ready = (hold == 0);
        lat = 0;
        while (!out_valid && lat < 4 * N) begin
            if (scramble) direction = 1'($urandom);
            step();
            lat++;
        end
        check_eq({name, " latency"}, 64'(lat), 64'(N));
        check_out8(name, e, ei);
        if (pend) begin
            for (int k = 0; k < N; k++) data_in[k*DW +: DW] = pv[k];
            direction = pdir;
            in_valid  = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            step();
            check_eq({name, " hold out_valid"}, 64'(out_valid), 64'd1);
            check_eq({name, " hold in_ready"}, 64'(in_ready), 64'd0);
            check_out8({name, " hold"}, e, ei);
        end
        out_ready = 1'b1;
        step();
        check_eq({name, " post out_valid"}, 64'(out_valid), 64'd0);
        check_eq({name, " post in_ready"}, 64'(in_ready), 64'd1);
        check_eq({name, " post busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run2(input string name, input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                        input bit dir);
        int   lat;
        bit   swp;
        logic [DW-1:0] e0, e1;
        swp = dir ? (a0 < a1) : (a0 > a1);
        e0  = swp ? a1 : a0;
        e1  = swp ? a0 : a1;
        data_in2   = {a1, a0};
        direction2 = dir;
        in_valid2  = 1'b1;
        out_ready2 = 1'b1;
        check_eq({name, " in_ready"}, 64'(in_ready2), 64'd1);
        step();
        in_valid2  = 1'b0;
        direction2 = ~dir;
        lat = 0;
        while (!out_valid2 && lat < 16) begin
            step();
            lat++;
        end
        check_eq({name, " latency"}, 64'(lat), 64'd2);
        check_eq({name, " lane0"}, 64'(data_out2[DW-1:0]), 64'(e0));
        check_eq({name, " lane1"}, 64'(data_out2[2*DW-1:DW]), 64'(e1));
`ifdef HSN_ITER_INDEX_EN
        check_eq({name, " idx"}, 64'(index_out2), swp ? 64'h1 : 64'h2);
`endif
        step();
        check_eq({name, " post out_valid"}, 64'(out_valid2), 64'd0);
    endtask

    initial begin
        vec8_t v, b, dummy;
        bit    seen;

        for (int k = 0; k < N; k++) dummy[k] = '0;

        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        check_eq("reset in_ready", 64'(in_ready), 64'd1);
        check_eq("reset out_valid", 64'(out_valid), 64'd0);
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset data_out lo", data_out[63:0], 64'd0);
        check_eq("reset data_out hi", data_out[255:192], 64'd0);
`ifdef HSN_ITER_INDEX_EN
        check_eq("reset index_out", 64'(index_out), 64'd0);
`endif
        check_eq("reset2 in_ready", 64'(in_ready2), 64'd1);
        check_eq("reset2 out_valid", 64'(out_valid2), 64'd0);

        // Reversed ramp, ascending.
        v = '{32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        send8("asc", v, 1'b0);
        recv8("asc", v, 1'b0, 0, 1'b0, 1'b0, dummy, 1'b0);

        // Duplicates, descending: stability shows in the index tags.
        v = '{32'd5, 32'd3, 32'd5, 32'd1, 32'd3, 32'd0, 32'd5, 32'd2};
        send8("desc", v, 1'b1);
        recv8("desc", v, 1'b1, 0, 1'b1, 1'b0, dummy, 1'b0);

        // Unsigned extremes.
        v = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF};
        send8("bound", v, 1'b0);
        recv8("bound", v, 1'b0, 0, 1'b0, 1'b0, dummy, 1'b0);

        // Backpressure with a pending vector that must wait for IDLE.
        for (int k = 0; k < N; k++) begin
            v[k] = rand_word();
            b[k] = rand_word();
        end
        send8("bpA", v, 1'b0);
        recv8("bpA", v, 1'b0, 5, 1'b0, 1'b1, b, 1'b1);
        send8("bpB", b, 1'b1);
        recv8("bpB", b, 1'b1, 0, 1'b0, 1'b0, dummy, 1'b0);

        // Reset on the cycle pass 3 would execute.
        for (int k = 0; k < N; k++) v[k] = rand_word();
        send8("rst", v, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst busy", 64'(busy), 64'd0);
        check_eq("midrst data_out lo", data_out[63:0], 64'd0);
        check_eq("midrst data_out hi", data_out[255:192], 64'd0);
`ifdef HSN_ITER_INDEX_EN
        check_eq("midrst index_out", 64'(index_out), 64'd0);
`endif
        seen = 1'b0;
        repeat (2 * N) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check_eq("midrst no emit", 64'(seen), 64'd0);

        // Random traffic with random backpressure and direction noise.
        for (int t = 0; t < 24; t++) begin
            bit d;
            d = 1'($urandom);
            for (int k = 0; k < N; k++) v[k] = rand_word();
            send8($sformatf("rnd%0d", t), v, d);
            recv8($sformatf("rnd%0d", t), v, d, int'($urandom_range(0, 3)),
                  1'b1, 1'b0, dummy, 1'b0);
        end

        // Two-lane instance.
        run2("n2 asc", 32'd9, 32'd4, 1'b0);
        run2("n2 desc", 32'd4, 32'd9, 1'b1);
        run2("n2 eq", 32'd6, 32'd6, 1'b1);
        for (int t = 0; t < 6; t++) begin
            run2($sformatf("n2 rnd%0d", t), rand_word(), rand_word(), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
